// File: rtl/spikes_phase_scheduler.sv
// Spike-tile sequencer: LFSR layout pick while idle, frame-timed retract/warn/armed cycle in play,
// and one hit per armed window per requester. Optional macro SPIKES_SPEEDUP_EN shortens retract per round.
module spikes_phase_scheduler #(
  parameter int NUM_LAYOUTS    = 5,
  parameter int RETRACT_FRAMES = 120,
  parameter int WARN_FRAMES    = 30,
  parameter int ARMED_FRAMES   = 60,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       game_on,
  input  logic       player_spike_col,
  input  logic       monster_spike_col,
  output logic [3:0] layout_sel,
  output logic       spikes_draw_en,
  output logic       spikes_lethal,
  output logic       player_hit,
  output logic       monster_hit,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RETRACTED = 2'd1,
    S_WARNING   = 2'd2,
    S_ARMED     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       blink_q, blink_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] layout_q, layout_d;
  logic       draw_q, draw_d;
  logic       lethal_q, lethal_d;
  logic       p_hit_q, p_hit_d;
  logic       m_hit_q, m_hit_d;
  logic       p_done_q, p_done_d;
  logic       m_done_q, m_done_d;
  logic [7:0] retract_len_s;

`ifdef SPIKES_SPEEDUP_EN
  logic [2:0] round_q, round_d;
  logic [8:0] shrink_s;

  // Retract length shrinks by 8 frames per completed round, floored at 16
  always_comb begin
    shrink_s = {3'b000, round_q, 3'b000};
    if (9'(RETRACT_FRAMES) < (shrink_s + 9'd16)) begin
      retract_len_s = 8'd16;
    end else begin
      retract_len_s = 8'(9'(RETRACT_FRAMES) - shrink_s);
    end
  end

  // Round counter: counts armed->retracted passes, saturating, cleared while idle
  always_comb begin
    round_d = round_q;
    if (state_q == S_IDLE) begin
      round_d = 3'd0;
    end else if ((state_q == S_ARMED) && (state_d == S_RETRACTED) && (round_q != 3'd7)) begin
      round_d = round_q + 3'd1;
    end else begin
      round_d = round_q;
    end
  end

  // Round counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      round_q <= 3'd0;
    end else begin
      round_q <= round_d;
    end
  end
`else
  assign retract_len_s = 8'(RETRACT_FRAMES);
`endif

  // Next-state, frame counting, LFSR, hit arbitration and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    lfsr_d   = lfsr_q;
    layout_d = layout_q;
    p_done_d = p_done_q;
    m_done_d = m_done_q;
    p_hit_d  = 1'b0;
    m_hit_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        layout_d = 4'(lfsr_q % 8'(NUM_LAYOUTS));
        p_done_d = 1'b0;
        m_done_d = 1'b0;
        if (game_on) begin
          state_d = S_RETRACTED;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RETRACTED: begin
        if (startOfFrame && (cnt_q == retract_len_s - 8'd1)) begin
          state_d = S_WARNING;
          cnt_d   = 8'd0;
          bcnt_d  = 8'd0;
          blink_d = 1'b1;
        end else if (startOfFrame) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WARNING: begin
        if (startOfFrame && (cnt_q == 8'(WARN_FRAMES) - 8'd1)) begin
          state_d  = S_ARMED;
          cnt_d    = 8'd0;
          bcnt_d   = 8'd0;
          blink_d  = 1'b0;
          p_done_d = 1'b0;
          m_done_d = 1'b0;
        end else if (startOfFrame) begin
          cnt_d = cnt_q + 8'd1;
          if (bcnt_q == 8'(BLINK_FRAMES) - 8'd1) begin
            bcnt_d  = 8'd0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ARMED: begin
        // Hits on the final armed cycle still count; the pulse lands in RETRACTED
        p_hit_d  = player_spike_col & ~p_done_q;
        m_hit_d  = monster_spike_col & ~m_done_q;
        p_done_d = p_done_q | player_spike_col;
        m_done_d = m_done_q | monster_spike_col;
        if (startOfFrame && (cnt_q == 8'(ARMED_FRAMES) - 8'd1)) begin
          state_d = S_RETRACTED;
          cnt_d   = 8'd0;
        end else if (startOfFrame) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving the round beats any frame tick and drops pending hits
    if ((state_q != S_IDLE) && !game_on) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      bcnt_d  = 8'd0;
      blink_d = 1'b0;
      p_hit_d = 1'b0;
      m_hit_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    draw_d   = (state_d == S_IDLE) | (state_d == S_ARMED) | ((state_d == S_WARNING) & blink_d);
    lethal_d = (state_d == S_ARMED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      bcnt_q   <= 8'd0;
      blink_q  <= 1'b0;
      lfsr_q   <= 8'hA5;
      layout_q <= 4'd0;
      draw_q   <= 1'b1;
      lethal_q <= 1'b0;
      p_hit_q  <= 1'b0;
      m_hit_q  <= 1'b0;
      p_done_q <= 1'b0;
      m_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      lfsr_q   <= lfsr_d;
      layout_q <= layout_d;
      draw_q   <= draw_d;
      lethal_q <= lethal_d;
      p_hit_q  <= p_hit_d;
      m_hit_q  <= m_hit_d;
      p_done_q <= p_done_d;
      m_done_q <= m_done_d;
    end
  end

  assign layout_sel     = layout_q;
  assign spikes_draw_en = draw_q;
  assign spikes_lethal  = lethal_q;
  assign player_hit     = p_hit_q;
  assign monster_hit    = m_hit_q;
  assign phase          = state_q;

endmodule

// File: tb/tb_spikes_phase_scheduler.sv
// Scoreboard bench for spikes_phase_scheduler: a frame-level reference model pushes expected
// outputs per clock; scenario tasks pop and compare. Covers SPIKES_SPEEDUP_EN when defined.
module tb_spikes_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, game_on, player_spike_col, monster_spike_col;
  logic [3:0] layout_sel;
  logic       spikes_draw_en, spikes_lethal, player_hit, monster_hit;
  logic [1:0] phase;

  spikes_phase_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (startOfFrame),
    .game_on           (game_on),
    .player_spike_col  (player_spike_col),
    .monster_spike_col (monster_spike_col),
    .layout_sel        (layout_sel),
    .spikes_draw_en    (spikes_draw_en),
    .spikes_lethal     (spikes_lethal),
    .player_hit        (player_hit),
    .monster_hit       (monster_hit),
    .phase             (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] phase;
    logic       draw;
    logic       lethal;
    logic       phit;
    logic       mhit;
    logic [3:0] layout;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tk = 0;
  int   period_v = 10;
  int   sof_cnt = 0;
  logic go_v = 1'b0;

  logic [1:0] m_phase;
  int         m_frames;
  logic [7:0] m_lfsr;
  logic [3:0] m_layout;
  logic       m_pdone, m_mdone;
`ifdef SPIKES_SPEEDUP_EN
  int         m_round;
`endif

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic int retract_len();
`ifdef SPIKES_SPEEDUP_EN
    int l;
    l = 120 - 8 * ((m_round > 7) ? 7 : m_round);
    return (l < 16) ? 16 : l;
`else
    return 120;
`endif
  endfunction

  task automatic model_step(input logic rst, input logic sof, input logic go, input logic pc, input logic mc);
    exp_t e;
    logic ph, mh;
    ph = 1'b0;
    mh = 1'b0;
    if (rst) begin
      m_phase = 2'd0; m_frames = 0; m_lfsr = 8'hA5; m_layout = 4'd0;
      m_pdone = 1'b0; m_mdone = 1'b0;
`ifdef SPIKES_SPEEDUP_EN
      m_round = 0;
`endif
    end else begin
      if (m_phase == 2'd3 && go) begin
        ph = pc && !m_pdone;
        mh = mc && !m_mdone;
        if (ph) m_pdone = 1'b1;
        if (mh) m_mdone = 1'b1;
      end
      if (m_phase != 2'd0 && !go) begin
        m_phase = 2'd0;
        m_frames = 0;
      end else begin
        case (m_phase)
          2'd0: begin
            m_layout = 4'(m_lfsr % 8'd5);
            m_lfsr   = lfsr_next(m_lfsr);
            m_pdone  = 1'b0;
            m_mdone  = 1'b0;
`ifdef SPIKES_SPEEDUP_EN
            m_round = 0;
`endif
            if (go) begin m_phase = 2'd1; m_frames = 0; end
          end
          2'd1: if (sof) begin
            m_frames++;
            if (m_frames == retract_len()) begin m_phase = 2'd2; m_frames = 0; end
          end
          2'd2: if (sof) begin
            m_frames++;
            if (m_frames == 30) begin
              m_phase = 2'd3; m_frames = 0; m_pdone = 1'b0; m_mdone = 1'b0;
            end
          end
          default: if (sof) begin
            m_frames++;
            if (m_frames == 60) begin
              m_phase = 2'd1; m_frames = 0;
`ifdef SPIKES_SPEEDUP_EN
              m_round++;
`endif
            end
          end
        endcase
      end
    end
    e.phase  = m_phase;
    e.draw   = (m_phase == 2'd0) || (m_phase == 2'd3) || (m_phase == 2'd2 && ((m_frames / 8) % 2 == 0));
    e.lethal = (m_phase == 2'd3);
    e.phit   = ph;
    e.mhit   = mh;
    e.layout = m_layout;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic pc, input logic mc);
    logic sof;
    sof = (period_v == 1) ? 1'b1 : ((tk % period_v) == (period_v - 1));
    tk++;
    if (sof) sof_cnt++;
    reset = 1'b0; startOfFrame = sof; game_on = go_v;
    player_spike_col = pc; monster_spike_col = mc;
    @(posedge clk);
    model_step(1'b0, sof, go_v, pc, mc);
    #1;
  endtask

  task automatic reset_cycle(input logic pc, input logic mc);
    reset = 1'b1; startOfFrame = 1'b1; game_on = go_v;
    player_spike_col = pc; monster_spike_col = mc;
    @(posedge clk);
    model_step(1'b1, 1'b1, go_v, pc, mc);
    #1;
  endtask

  // Advance until the DUT shows the target phase, tracking every output against the model
  task automatic wait_phase(input logic [1:0] target, input logic pc, input logic mc, input int budget,
                            output int hits, output int ncyc);
    exp_t e;
    bit   done;
    done = 1'b0; hits = 0; ncyc = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle(pc, mc);
      e = sb_q.pop_front();
      ncyc++;
      checks++;
      if ({phase, spikes_draw_en, spikes_lethal, player_hit, monster_hit} !==
          {e.phase, e.draw, e.lethal, e.phit, e.mhit}) begin
        failures++;
        $display("FAIL track phase/draw/lethal/phit/mhit got=%b exp=%b", {phase, spikes_draw_en, spikes_lethal,
                 player_hit, monster_hit}, {e.phase, e.draw, e.lethal, e.phit, e.mhit});
      end
      hits += int'(player_hit) + int'(monster_hit);
      if (phase == target) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wait_phase_timeout got phase=%0d exp=%0d", phase, target);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    go_v = 1'b0;
    reset_cycle(1'b0, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if ({layout_sel, phase, spikes_draw_en, spikes_lethal, player_hit, monster_hit} !== 10'b0000_00_1_0_0_0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", {layout_sel, phase, spikes_draw_en, spikes_lethal,
               player_hit, monster_hit}, 10'b0000_00_1_0_0_0);
    end
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (layout_sel !== e.layout || phase !== 2'd0 || spikes_draw_en !== 1'b1) begin
        failures++;
        $display("FAIL idle_layout cyc=%0d got layout=%0d phase=%0d draw=%b exp layout=%0d phase=0 draw=1",
                 i, layout_sel, phase, spikes_draw_en, e.layout);
      end
    end
    checks++;
    if (layout_sel > 4'd4) begin
      failures++;
      $display("FAIL layout_range got=%0d exp<=4", layout_sel);
    end
  endtask

  task automatic test_phase_cycle();
    exp_t       e;
    logic [1:0] prev;
    int         ntrans;
    bit         expd;
    go_v = 1'b1; period_v = 10; tk = 0; sof_cnt = 0; prev = 2'd0; ntrans = 0;
    for (int i = 0; i < 2300 && ntrans < 4; i++) begin
      cycle(1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({phase, spikes_draw_en, spikes_lethal} !== {e.phase, e.draw, e.lethal}) begin
        failures++;
        $display("FAIL cycle_track sof=%0d got=%b exp=%b", sof_cnt, {phase, spikes_draw_en, spikes_lethal},
                 {e.phase, e.draw, e.lethal});
      end
      if (phase == 2'd2) begin
        expd = (((sof_cnt - 120) / 8) % 2) == 0;
        checks++;
        if (spikes_draw_en !== expd) begin
          failures++;
          $display("FAIL warn_blink sof=%0d got=%b exp=%b", sof_cnt, spikes_draw_en, expd);
        end
      end
      if (phase != prev) begin
        checks++;
        if (!((prev == 2'd0 && phase == 2'd1 && sof_cnt == 0) || (prev == 2'd1 && phase == 2'd2 && sof_cnt == 120) ||
              (prev == 2'd2 && phase == 2'd3 && sof_cnt == 150) || (prev == 2'd3 && phase == 2'd1 && sof_cnt == 210))) begin
          failures++;
          $display("FAIL phase_timing got %0d->%0d at frame %0d exp 0->1@0 1->2@120 2->3@150 3->1@210",
                   prev, phase, sof_cnt);
        end
        ntrans++;
        prev = phase;
      end
    end
    checks++;
    if (ntrans != 4) begin
      failures++;
      $display("FAIL phase_transitions got=%0d exp=4", ntrans);
    end
  endtask

  task automatic test_hit_once();
    exp_t e;
    int   h, n, pulses, first;
    period_v = 2;
    for (int w = 0; w < 2; w++) begin
      wait_phase(2'd1, 1'b0, 1'b0, 600, h, n);
      wait_phase(2'd3, 1'b0, 1'b0, 600, h, n);
      pulses = 0; first = -1;
      for (int i = 0; i < 50; i++) begin
        cycle(1'b1, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (player_hit !== e.phit || monster_hit !== 1'b0) begin
          failures++;
          $display("FAIL hold_hit win=%0d cyc=%0d got p=%b m=%b exp p=%b m=0", w, i, player_hit, monster_hit, e.phit);
        end
        if (player_hit === 1'b1) begin
          pulses++;
          if (first < 0) first = i;
        end
      end
      checks++;
      if (pulses != 1 || first != 0) begin
        failures++;
        $display("FAIL hit_once win=%0d got pulses=%0d first=%0d exp pulses=1 first=0", w, pulses, first);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   h, n;
    wait_phase(2'd1, 1'b0, 1'b0, 600, h, n);
    wait_phase(2'd2, 1'b1, 1'b1, 600, h, n);
    checks++;
    if (h != 0) begin
      failures++;
      $display("FAIL hits_in_retracted got=%0d exp=0", h);
    end
    wait_phase(2'd3, 1'b1, 1'b1, 600, h, n);
    checks++;
    if (h != 0) begin
      failures++;
      $display("FAIL hits_in_warning got=%0d exp=0", h);
    end
    cycle(1'b1, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if ({player_hit, monster_hit} !== 2'b11 || {e.phit, e.mhit} !== 2'b11) begin
      failures++;
      $display("FAIL both_hit got=%b exp=11 (model %b)", {player_hit, monster_hit}, {e.phit, e.mhit});
    end
    cycle(1'b0, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if ({player_hit, monster_hit} !== 2'b00) begin
      failures++;
      $display("FAIL both_hit_pulse_width got=%b exp=00", {player_hit, monster_hit});
    end
  endtask

  task automatic test_game_off();
    exp_t       e;
    int         h, n, changes;
    logic [3:0] last;
    wait_phase(2'd2, 1'b0, 1'b0, 800, h, n);
    wait_phase(2'd2, 1'b0, 1'b0, 5, h, n);
    go_v = 1'b0;
    cycle(1'b0, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if ({phase, spikes_draw_en, spikes_lethal} !== 4'b00_1_0 || e.phase !== 2'd0) begin
      failures++;
      $display("FAIL game_off_exit got phase=%0d draw=%b lethal=%b exp phase=0 draw=1 lethal=0",
               phase, spikes_draw_en, spikes_lethal);
    end
    changes = 0; last = layout_sel;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (layout_sel !== e.layout || phase !== 2'd0) begin
        failures++;
        $display("FAIL idle_resume cyc=%0d got layout=%0d phase=%0d exp layout=%0d phase=0",
                 i, layout_sel, phase, e.layout);
      end
      if (layout_sel != last) changes++;
      last = layout_sel;
    end
    checks++;
    if (changes == 0) begin
      failures++;
      $display("FAIL layout_resumes got changes=0 exp>0");
    end
  endtask

  task automatic test_reset_mid_armed();
    exp_t e;
    int   h, n;
    go_v = 1'b1;
    wait_phase(2'd3, 1'b0, 1'b0, 800, h, n);
    wait_phase(2'd3, 1'b1, 1'b0, 3, h, n);
    go_v = 1'b0;
    reset_cycle(1'b1, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if ({layout_sel, phase, spikes_draw_en, spikes_lethal, player_hit, monster_hit} !== 10'b0000_00_1_0_0_0) begin
      failures++;
      $display("FAIL reset_mid_armed got=%b exp=%b", {layout_sel, phase, spikes_draw_en, spikes_lethal,
               player_hit, monster_hit}, 10'b0000_00_1_0_0_0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (layout_sel !== e.layout) begin
        failures++;
        $display("FAIL reseed_layout cyc=%0d got=%0d exp=%0d", i, layout_sel, e.layout);
      end
    end
  endtask

`ifdef SPIKES_SPEEDUP_EN
  task automatic test_speedup();
    int h, n, expl;
    period_v = 1;
    for (int pass = 0; pass < 2; pass++) begin
      go_v = 1'b1;
      for (int r = 0; r < ((pass == 0) ? 9 : 1); r++) begin
        wait_phase(2'd1, 1'b0, 1'b0, 400, h, n);
        wait_phase(2'd2, 1'b0, 1'b0, 400, h, n);
        expl = 120 - 8 * ((r > 7) ? 7 : r);
        if (expl < 16) expl = 16;
        checks++;
        if (n != expl) begin
          failures++;
          $display("FAIL speedup_len pass=%0d round=%0d got=%0d exp=%0d", pass, r, n, expl);
        end
      end
      go_v = 1'b0;
      wait_phase(2'd0, 1'b0, 1'b0, 4, h, n);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; game_on = 1'b0;
    player_spike_col = 1'b0; monster_spike_col = 1'b0;
    #2;
    test_reset();
    test_phase_cycle();
    test_hit_once();
    test_simultaneous();
    test_game_off();
    test_reset_mid_armed();
`ifdef SPIKES_SPEEDUP_EN
    test_speedup();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spikes_phase_scheduler.md
Name: spikes_phase_scheduler

Overview:
- Sequences the spike-tile layer.
- While the game is off, it picks one of the spike layouts pseudo-randomly and drives the layout-select input of the spike matrix bitmap.
- While the game is on, it runs a frame-timed retract/warn/armed cycle. This gates spike drawing and lethality.
- It arbitrates spike-collision hits between the player and the monster, so each receives at most one hit per armed window.

Parameters:
- NUM_LAYOUTS, 5, number of selectable spike layouts; layout_sel range is 0..NUM_LAYOUTS-1.
- RETRACT_FRAMES, 120, frames spent retracted (invisible, harmless).
- WARN_FRAMES, 30, frames spent warning (blinking, harmless).
- ARMED_FRAMES, 60, frames spent armed (visible, lethal).
- BLINK_FRAMES, 8, half-period of the warning blink, in frames.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- game_on  in  1  high while a round is running
- player_spike_col  in  1  player/spike pixel collision this cycle
- monster_spike_col  in  1  monster/spike pixel collision this cycle
- layout_sel  out  4  layout index to the spike matrix bitmap
- spikes_draw_en  out  1  spike layer may draw (AND-ed with its drawingRequest)
- spikes_lethal  out  1  spikes currently damage
- player_hit  out  1  one-cycle pulse, player damaged by spikes
- monster_hit  out  1  one-cycle pulse, monster damaged by spikes
- phase  out  2  0 IDLE, 1 RETRACTED, 2 WARNING, 3 ARMED (debug/HUD)

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- On reset:
  - FSM goes to IDLE; frame counter = 0; blink = 0.
  - 8-bit LFSR = 8'hA5; layout_sel = 0.
  - All outputs 0, except spikes_draw_en = 1 (IDLE shows the selected layout statically).
- LFSR:
  - Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form.
  - Advances every clk while in IDLE; frozen otherwise.
  - Never reaches zero; the reset seed is nonzero.
- IDLE:
  - layout_sel <= LFSR mod NUM_LAYOUTS, registered every cycle.
  - spikes_draw_en = 1, spikes_lethal = 0.
  - On game_on = 1: go to RETRACTED and clear the frame counter. layout_sel holds its last value for the whole round.
- RETRACTED:
  - draw_en = 0, lethal = 0.
  - The counter increments on startOfFrame.
  - When the counter reaches RETRACT_FRAMES-1 and startOfFrame is high: go to WARNING and clear the counter.
- WARNING:
  - lethal = 0. blink toggles every BLINK_FRAMES frames, starting at 1. draw_en = blink.
  - After WARN_FRAMES frames: go to ARMED and clear the counter and blink.
- ARMED:
  - draw_en = 1, lethal = 1.
  - After ARMED_FRAMES frames: go to RETRACTED and clear the counter.
- game_on = 0 in any non-IDLE state: go to IDLE on the next cycle. Counter and blink clear. Any pending hit pulse is suppressed.
- Hit arbitration:
  - Per-requester "already hit" flags. Both clear on entry to ARMED and in IDLE.
  - In ARMED, a collision with its flag clear emits a 1-cycle hit pulse on the following cycle and sets the flag.
  - Player and monster are independent; simultaneous collisions produce both pulses in the same cycle.
  - Collisions outside ARMED are ignored.
  - A collision on the final ARMED cycle (the transition cycle) is still honoured. Its pulse appears 1 cycle later, during RETRACTED.
- Latency:
  - phase, draw_en and lethal are registered; they change 1 cycle after the transition condition.
  - Hit pulses follow their collision by 1 cycle.
- Counters are 8 bits wide. Parameters must be between 1 and 255; a value of 1 means a single-frame phase.
- startOfFrame coinciding with game_on falling: the exit to IDLE wins.

Optional Feature:
- Macro: SPIKES_SPEEDUP_EN.
- Defined:
  - A 3-bit round counter increments on each ARMED→RETRACTED transition, saturating at 7.
  - The effective RETRACT length = RETRACT_FRAMES - 8*round_count, floored at 16 frames.
  - The round counter clears in IDLE and on reset.
- Undefined: RETRACT length is constant and no round counter exists.

Test Plan:
- Reset with game_on = 0 → layout_sel = 0, phase = 0, draw_en = 1, lethal = 0. After 100 cycles, layout_sel ∈ {0..4} and matches a model LFSR seeded 8'hA5.
- Raise game_on, then pulse startOfFrame every 10 cycles → phase goes 1→2 after 120 frames, 2→3 after 30 more, 3→1 after 60 more. During WARNING, draw_en toggles every 8 frames starting at 1.
- In ARMED, hold player_spike_col = 1 for 50 cycles → exactly one player_hit pulse, 1 cycle after the first collision. In the next ARMED window, the same stimulus gives one more pulse.
- Assert player and monster collisions in the same ARMED cycle → player_hit and monster_hit both pulse in the same next cycle. Collisions in RETRACTED and WARNING give no pulses.
- Drop game_on mid-WARNING → phase = 0 the next cycle, draw_en = 1, layout_sel resumes changing. Assert reset mid-ARMED → all reset values next cycle.
- With SPIKES_SPEEDUP_EN defined → RETRACTED lasts 120, 112, 104, … frames, never below 16; it returns to 120 after a pass through IDLE.
